// File: rtl/updown_bounce_counter_if.sv
// Bundle of control, limit and status signals for updown_bounce_counter.
// master drives the controls; slave is the counter itself.
interface updown_bounce_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             turn;
    logic             at_lo;
    logic             at_hi;
    logic             cfg_err;

    modport master (
        output en, mode, lo, hi, load, load_val,
        input  count, dir, turn, at_lo, at_hi, cfg_err
    );

    modport slave (
        input  en, mode, lo, hi, load, load_val,
        output count, dir, turn, at_lo, at_hi, cfg_err
    );
endinterface

// File: rtl/updown_bounce_counter.sv
// Up/down counter bounded by [lo, hi] with bounce, wrap and hold modes.
// Steps are computed one bit wider than the count so they never wrap.
module updown_bounce_counter #(
    parameter int          WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_bounce_counter_if.slave bus
);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'b00,
        M_UP     = 2'b01,
        M_DOWN   = 2'b10,
        M_HOLD   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             turn_q, turn_d;

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] hi_x;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;
    logic [WIDTH:0] lo_plus;
    logic           cfg_err;
    logic           out_rng;
    mode_e          mode;

    assign mode    = mode_e'(bus.mode);
    assign cnt_x   = {1'b0, count_q};
    assign hi_x    = {1'b0, bus.hi};
    assign up_sum  = cnt_x + STEP_W;
    assign dn_diff = cnt_x - STEP_W;
    // count-STEP <= lo rewritten as count <= lo+STEP avoids borrow handling
    assign lo_plus = {1'b0, bus.lo} + STEP_W;
    assign cfg_err = bus.lo > bus.hi;
    assign out_rng = (count_q < bus.lo) || (count_q > bus.hi);

    assign bus.count   = count_q;
    assign bus.dir     = dir_q;
    assign bus.turn    = turn_q;
    assign bus.at_lo   = count_q == bus.lo;
    assign bus.at_hi   = count_q == bus.hi;
    assign bus.cfg_err = cfg_err;

    // Next-state: load beats bad config beats enabled stepping
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        turn_d  = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
            dir_d   = 1'b0;
        end else if (cfg_err) begin
            count_d = count_q;
        end else if (bus.en && mode != M_HOLD) begin
            if (out_rng) begin
                count_d = bus.lo;
                dir_d   = 1'b0;
            end else if (bus.lo == bus.hi) begin
                count_d = bus.lo;
            end else begin
                case (mode)
                    M_BOUNCE: begin
                        if (!dir_q) begin
                            if (up_sum >= hi_x) begin
                                count_d = bus.hi;
                                dir_d   = 1'b1;
                                turn_d  = 1'b1;
                            end else begin
                                count_d = up_sum[WIDTH-1:0];
                            end
                        end else begin
                            if (cnt_x <= lo_plus) begin
                                count_d = bus.lo;
                                dir_d   = 1'b0;
                                turn_d  = 1'b1;
                            end else begin
                                count_d = dn_diff[WIDTH-1:0];
                            end
                        end
                    end
                    M_UP: begin
                        dir_d = 1'b0;
                        if (up_sum > hi_x) begin
                            count_d = bus.lo;
                            turn_d  = 1'b1;
                        end else begin
                            count_d = up_sum[WIDTH-1:0];
                        end
                    end
                    M_DOWN: begin
                        dir_d = 1'b1;
                        if (cnt_x < lo_plus) begin
                            count_d = bus.hi;
                            turn_d  = 1'b1;
                        end else begin
                            count_d = dn_diff[WIDTH-1:0];
                        end
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    // State register with asynchronous reset to count 0, direction up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
        end
    end
endmodule

// File: tb/tb_updown_bounce_counter.sv
// Directed bench for updown_bounce_counter: vector table plus
// hand sequences for triangle, odd step and asynchronous reset.
module tb_updown_bounce_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    updown_bounce_counter_if #(.WIDTH(3)) b3();
    updown_bounce_counter_if #(.WIDTH(8)) b8();
    updown_bounce_counter_if #(.WIDTH(8)) bs();

    updown_bounce_counter #(.WIDTH(3), .STEP(1)) u3 (
        .clk(clk), .rst(rst), .bus(b3)
    );
    updown_bounce_counter #(.WIDTH(8), .STEP(1)) u8 (
        .clk(clk), .rst(rst), .bus(b8)
    );
    updown_bounce_counter #(.WIDTH(8), .STEP(3)) us (
        .clk(clk), .rst(rst), .bus(bs)
    );

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       load;
        logic [7:0] lv;
        logic [7:0] c;
        logic       d;
        logic       t;
        logic       al;
        logic       ah;
        logic       ce;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic en, input logic [1:0] mode,
        input logic [7:0] lo, input logic [7:0] hi,
        input logic load, input logic [7:0] lv,
        input logic [7:0] c, input logic d, input logic t,
        input logic al, input logic ah, input logic ce
    );
        vec_t r;
        r.en = en; r.mode = mode; r.lo = lo; r.hi = hi;
        r.load = load; r.lv = lv; r.c = c; r.d = d; r.t = t;
        r.al = al; r.ah = ah; r.ce = ce;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tc[7];
        int td[7];
        int tt[7];

        b3.en = 1; b3.mode = 0; b3.lo = 0; b3.hi = 7;
        b3.load = 0; b3.load_val = 0;
        b8.en = 0; b8.mode = 0; b8.lo = 0; b8.hi = 0;
        b8.load = 0; b8.load_val = 0;
        bs.en = 0; bs.mode = 0; bs.lo = 0; bs.hi = 0;
        bs.load = 0; bs.load_val = 0;

        #2;
        chk("rst.u3.count", 32'(b3.count), 0);
        chk("rst.u8.count", 32'(b8.count), 0);
        chk("rst.u8.dir", 32'(b8.dir), 0);
        chk("rst.u8.turn", 32'(b8.turn), 0);
        chk("rst.us.count", 32'(bs.count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 15; i++) begin
            int ec;
            step();
            ec = (i <= 7) ? i : ((i <= 14) ? 14 - i : 1);
            chk($sformatf("tri%0d.count", i), 32'(b3.count), 32'(ec));
            chk($sformatf("tri%0d.dir", i), 32'(b3.dir),
                32'(i >= 7 && i < 14));
            chk($sformatf("tri%0d.turn", i), 32'(b3.turn),
                32'(i == 7 || i == 14));
        end

        bs.en = 1; bs.mode = 0; bs.lo = 2; bs.hi = 10;
        bs.load = 1; bs.load_val = 2;
        step();
        chk("step3.load", 32'(bs.count), 2);
        bs.load = 0;
        tc = '{5, 8, 10, 7, 4, 2, 5};
        td = '{0, 0, 1, 1, 1, 0, 0};
        tt = '{0, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("step3.%0d.count", i), 32'(bs.count), 32'(tc[i]));
            chk($sformatf("step3.%0d.dir", i), 32'(bs.dir), 32'(td[i]));
            chk($sformatf("step3.%0d.turn", i), 32'(bs.turn), 32'(tt[i]));
        end
        bs.en = 0;

        tbl.push_back(v(1,1,5,8,1,7,   7,0,0,0,0,0));
        tbl.push_back(v(1,1,5,8,0,0,   8,0,0,0,1,0));
        tbl.push_back(v(1,1,5,8,0,0,   5,0,1,1,0,0));
        tbl.push_back(v(1,1,5,8,0,0,   6,0,0,0,0,0));
        tbl.push_back(v(1,2,5,8,1,6,   6,0,0,0,0,0));
        tbl.push_back(v(1,2,5,8,0,0,   5,1,0,1,0,0));
        tbl.push_back(v(1,2,5,8,0,0,   8,1,1,0,1,0));
        tbl.push_back(v(1,2,5,8,0,0,   7,1,0,0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1,3,5,8,0,0, 7,1,0,0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0,0,5,8,0,0, 7,1,0,0,0,0));
        tbl.push_back(v(1,0,5,8,1,3,   3,0,0,0,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   5,0,0,1,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   6,0,0,0,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   7,0,0,0,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   8,1,1,0,1,0));
        tbl.push_back(v(1,0,5,6,0,0,   5,0,0,1,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   6,0,0,0,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   7,0,0,0,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   8,1,1,0,1,0));
        tbl.push_back(v(1,0,5,8,0,0,   7,1,0,0,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   6,1,0,0,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   5,0,1,1,0,0));
        tbl.push_back(v(1,0,5,8,0,0,   6,0,0,0,0,0));
        tbl.push_back(v(1,0,5,8,1,200, 200,0,0,0,0,0));
        tbl.push_back(v(1,0,5,100,0,0, 5,0,0,1,0,0));
        tbl.push_back(v(1,0,5,100,1,200, 200,0,0,0,0,0));
        tbl.push_back(v(1,0,101,100,0,0, 200,0,0,0,0,1));
        tbl.push_back(v(1,0,101,100,0,0, 200,0,0,0,0,1));
        tbl.push_back(v(1,0,101,100,1,50, 50,0,0,0,0,1));
        tbl.push_back(v(1,0,101,100,0,0, 50,0,0,0,0,1));
        tbl.push_back(v(1,0,10,60,0,0,  51,0,0,0,0,0));
        tbl.push_back(v(1,0,10,52,0,0,  52,1,1,0,1,0));
        tbl.push_back(v(1,0,52,52,0,0,  52,1,0,1,1,0));
        tbl.push_back(v(1,0,52,60,0,0,  52,0,1,1,0,0));
        tbl.push_back(v(1,2,0,9,1,0,    0,0,0,1,0,0));
        tbl.push_back(v(1,2,0,9,0,0,    9,1,1,0,1,0));
        tbl.push_back(v(1,1,250,255,1,255, 255,0,0,0,1,0));
        tbl.push_back(v(1,1,250,255,0,0,   250,0,1,1,0,0));
        tbl.push_back(v(1,0,250,255,1,254, 254,0,0,0,0,0));
        tbl.push_back(v(1,0,250,255,0,0,   255,1,1,0,1,0));
        tbl.push_back(v(1,0,250,255,0,0,   254,1,0,0,0,0));
        tbl.push_back(v(1,1,250,255,0,0,   255,0,0,0,1,0));

        foreach (tbl[i]) begin
            b8.en = tbl[i].en; b8.mode = tbl[i].mode;
            b8.lo = tbl[i].lo; b8.hi = tbl[i].hi;
            b8.load = tbl[i].load; b8.load_val = tbl[i].lv;
            step();
            chk($sformatf("v%0d.count", i), 32'(b8.count), 32'(tbl[i].c));
            chk($sformatf("v%0d.dir", i), 32'(b8.dir), 32'(tbl[i].d));
            chk($sformatf("v%0d.turn", i), 32'(b8.turn), 32'(tbl[i].t));
            chk($sformatf("v%0d.at_lo", i), 32'(b8.at_lo), 32'(tbl[i].al));
            chk($sformatf("v%0d.at_hi", i), 32'(b8.at_hi), 32'(tbl[i].ah));
            chk($sformatf("v%0d.cfg_err", i), 32'(b8.cfg_err),
                32'(tbl[i].ce));
        end

        b8.en = 1; b8.mode = 0; b8.lo = 0; b8.hi = 9;
        b8.load = 1; b8.load_val = 8;
        step();
        b8.load = 0;
        tc = '{9, 8, 7, 6, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("pre_rst%0d.count", i), 32'(b8.count),
                32'(tc[i]));
        end
        chk("pre_rst.dir", 32'(b8.dir), 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst.count", 32'(b8.count), 0);
        chk("async_rst.dir", 32'(b8.dir), 0);
        chk("async_rst.turn", 32'(b8.turn), 0);
        step();
        chk("in_rst.count", 32'(b8.count), 0);
        #3 rst = 1'b0;
        step();
        chk("post_rst.count", 32'(b8.count), 1);
        chk("post_rst.dir", 32'(b8.dir), 0);
        chk("post_rst.turn", 32'(b8.turn), 0);
        step();
        chk("post_rst2.count", 32'(b8.count), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/updown_bounce_counter.md
UPDOWN_BOUNCE_COUNTER -- requirements
Module: updown_bounce_counter

Interface
REQ-001 Parameter WIDTH SHALL be defined: default 8, counter width in bits; legal range 2..32.
REQ-002 Parameter STEP SHALL be defined: default 1, increment/decrement magnitude; legal range 1..2^(WIDTH-1).
REQ-003 Port clk SHALL be defined: input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be defined: input, 1 bit, asynchronous active-high reset.
REQ-005 Port en SHALL be defined: input, 1 bit, step enable.
REQ-006 Port mode SHALL be defined: input, 2 bits; 00 bounce, 01 up-wrap, 10 down-wrap, 11 hold.
REQ-007 Ports lo and hi SHALL be defined: input, WIDTH bits each, inclusive lower and upper count limits, unsigned.
REQ-008 Port load SHALL be defined: input, 1 bit, synchronous load strobe.
REQ-009 Port load_val SHALL be defined: input, WIDTH bits, value written on load.
REQ-010 Port count SHALL be defined: output, WIDTH bits, registered count.
REQ-011 Port dir SHALL be defined: output, 1 bit, registered direction; 0 up, 1 down.
REQ-012 Port turn SHALL be defined: output, 1 bit, registered one-cycle pulse on reversal or wrap.
REQ-013 Ports at_lo and at_hi SHALL be defined: output, 1 bit each, combinational flags for count==lo and count==hi.
REQ-014 Port cfg_err SHALL be defined: output, 1 bit, combinational flag for lo>hi.

Function
REQ-015 Per clock edge, priority SHALL be: load, then cfg_err, then en.
REQ-016 Load: count<=load_val, dir<=0, turn<=0, regardless of en, mode, or limits.
REQ-017 cfg_err=1 without load: count and dir hold, turn<=0.
REQ-018 en=0 or mode=11: count and dir hold, turn<=0.
REQ-019 Out-of-range recovery: on an enabled step with count<lo or count>hi, count<=lo, dir<=0, turn<=0; no arithmetic step is taken that cycle.
REQ-020 Degenerate window: lo==hi on an enabled step gives count<=lo, dir holds, turn<=0.
REQ-021 Arithmetic SHALL be evaluated at WIDTH+1 bits so that neither count+STEP nor count-STEP wraps internally.
REQ-022 Bounce, dir=0: if count+STEP>=hi, then count<=hi, dir<=1, turn<=1; otherwise count<=count+STEP.
REQ-023 Bounce, dir=1: if count-STEP<=lo (including borrow), then count<=lo, dir<=0, turn<=1; otherwise count<=count-STEP.
REQ-024 Up-wrap: dir<=0; if count+STEP>hi, then count<=lo, turn<=1; otherwise count<=count+STEP, turn<=0.
REQ-025 Down-wrap: dir<=1; if count-STEP<lo (including borrow), then count<=hi, turn<=1; otherwise count<=count-STEP, turn<=0.
REQ-026 turn SHALL be high for exactly the one cycle following the reversing or wrapping edge; consecutive reversals produce consecutive pulses.
REQ-027 A mode change SHALL take effect on the next enabled edge using the current count; no idle cycle is inserted.
REQ-028 lo and hi SHALL be sampled every cycle and may change at any time; REQ-019 handles the resulting out-of-range states.
REQ-029 Latency: count, dir, and turn SHALL reflect the inputs of the preceding edge (1 cycle); at_lo, at_hi, and cfg_err are combinational.

Reset
REQ-030 While rst=1, count=0, dir=0, and turn=0 immediately, independent of clk.
REQ-031 After rst deasserts, the first rising edge SHALL apply normal rules from count=0.
REQ-032 rst asserted mid-sequence SHALL abandon any direction or wrap state, with no turn pulse on release.

Verification
REQ-033 Bounce triangle (WIDTH=3, STEP=1, lo=0, hi=7, en=1, mode=00 from reset): count 0,1,...,7,6,...,0,1; turn high in the cycles count=7 and count=0 first appear; dir toggles with it.
REQ-034 Non-multiple step (WIDTH=8, STEP=3, lo=2, hi=10, mode=00, load 2): count 2,5,8,10,7,4,2,5; turn at 10 and 2.
REQ-035 Wrap modes (WIDTH=8, STEP=1, lo=5, hi=8): mode=01 from load 7 gives 7,8,5,6 with turn on 5; mode=10 from load 6 gives 6,5,8,7 with turn on 8.
REQ-036 Limit change: count=200, set hi=100 with en=1 → next count=lo, dir=0, turn=0; with lo=101, hi=100 → cfg_err=1 and count holds until corrected.
REQ-037 Priority and holds: load=1 with en=1 loads load_val; en=0 or mode=11 holds count and dir for 5 cycles with turn=0.
REQ-038 Asynchronous reset mid-count: assert rst between edges at count=6, dir=1 → count=0 and dir=0 before the next edge, and counting resumes up after release.
